// File: rtl/instruction_fetch_unit.sv
// Sequential 40-bit instruction fetcher: issues 5-byte reads at the PC, queues the
// returned words with their addresses, and hands them to decode over valid/ready.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectPc,
    output logic                  memRead,
    output logic [ADDR_WIDTH-1:0] memAddress,
    input  logic [39:0]           memData,
    input  logic                  memComplete,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [39:0]           instrData,
    output logic [ADDR_WIDTH-1:0] instrPc,
    output logic                  busy
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} fetch_state_t;

    fetch_state_t          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] pc_plus5;
    logic [CNT_W-1:0]      count_reg, count_after;
    logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
    logic [39:0]           data_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
    logic                  full, push, pop;

    assign full       = (count_reg == CNT_W'(QUEUE_DEPTH));
    assign instrValid = (count_reg != '0);
    assign instrData  = instrValid ? data_mem[rd_ptr_reg] : '0;
    assign instrPc    = instrValid ? pc_mem[rd_ptr_reg] : '0;
    assign memRead    = (state_reg == FETCH);
    assign memAddress = addr_reg;
    assign busy       = (state_reg != IDLE);

    // A redirect kills both the pop and any push in the same cycle.
    assign pop         = instrValid && instrReady && !redirect;
    assign push        = (state_reg == FETCH) && memComplete && !redirect && (!full || pop);
    assign count_after = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign pc_plus5    = pc_reg + ADDR_WIDTH'(5);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    pc_next = redirectPc;
                end else if (enable && !full) begin
                    state_next = FETCH;
                    addr_next  = pc_reg;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = redirectPc;
                    if (!memComplete) begin
                        state_next = DISCARD;
                    end else if (enable) begin
                        addr_next = redirectPc;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (memComplete) begin
                    pc_next = pc_plus5;
                    if (enable && count_after != CNT_W'(QUEUE_DEPTH)) begin
                        addr_next = pc_plus5;
                    end else if (count_after == CNT_W'(QUEUE_DEPTH)) begin
                        state_next = STALL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_next    = redirectPc;
                    state_next = IDLE;
                end else if (enable && !full) begin
                    state_next = FETCH;
                    addr_next  = pc_reg;
                end
            end
            DISCARD: begin
                // The controller still owes one completion; swallow it before reissuing.
                if (redirect) begin
                    pc_next = redirectPc;
                end
                if (memComplete) begin
                    if (enable) begin
                        state_next = FETCH;
                        addr_next  = redirect ? redirectPc : pc_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || redirect) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            count_reg <= count_after;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset: visibility is governed by count_reg.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            data_mem[wr_ptr_reg] <= memData;
            pc_mem[wr_ptr_reg]   <= pc_reg;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a fixed-latency 5-byte memory model.
module tb_instruction_fetch_unit;
    localparam int              AW     = 32;
    localparam logic [AW-1:0]   RST_PC = 32'hFFFF_FFFD;
    localparam int              LAT    = 6;

    logic          clk = 1'b0;
    logic          reset, enable, redirect, instrReady;
    logic [AW-1:0] redirectPc;
    logic          memRead, instrValid, busy;
    logic [AW-1:0] memAddress, instrPc;
    logic [39:0]   instrData;
    logic [39:0]   memData = '0;
    logic          memComplete = 1'b0;

    int            errors = 0;
    int            checks = 0;
    int            base;
    logic [AW-1:0] got_pc[$];
    logic [39:0]   got_data[$];
    logic          model_busy = 1'b0;
    int            model_cnt = 0;
    logic [AW-1:0] model_addr = '0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(2),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .memRead    (memRead),
        .memAddress (memAddress),
        .memData    (memData),
        .memComplete(memComplete),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instrData  (instrData),
        .instrPc    (instrPc),
        .busy       (busy)
    );

    function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
        return a[7:0] * 8'd3 + 8'h11;
    endfunction

    function automatic logic [39:0] instr_at(input logic [AW-1:0] a);
        logic [39:0] v = '0;
        for (int i = 0; i < 5; i++) v = {v[31:0], byte_at(a + AW'(i))};
        return v;
    endfunction

    // Memory controller: accepts a request when memRead is seen idle, answers LAT cycles later.
    always @(posedge clk) begin
        #1;
        memComplete = 1'b0;
        memData     = 40'hDE_AD_BE_EF_00;
        if (model_busy) begin
            if (model_cnt == 1) begin
                memComplete = 1'b1;
                memData     = instr_at(model_addr);
                model_busy  = 1'b0;
            end else begin
                model_cnt = model_cnt - 1;
            end
        end else if (memRead) begin
            model_addr = memAddress;
            model_cnt  = LAT;
            model_busy = 1'b1;
        end
    end

    // Record every accepted handshake (a redirect cancels the pop).
    always @(negedge clk) begin
        #2;
        if (reset && instrValid && instrReady && !redirect) begin
            got_pc.push_back(instrPc);
            got_data.push_back(instrData);
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic check_got(input int idx, input logic [AW-1:0] pc, input string tag);
        logic [AW-1:0] p = '1;
        logic [39:0]   d = '1;
        if (idx < got_pc.size()) begin
            p = got_pc[idx];
            d = got_data[idx];
        end
        check_value({tag, "_pc"}, 64'(p), 64'(pc));
        check_value({tag, "_data"}, 64'(d), 64'(instr_at(pc)));
    endtask

    task automatic wait_got(input int n, input string tag);
        int cyc = 0;
        while (got_pc.size() < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_value({tag, "_count"}, 64'(got_pc.size() >= n), 64'd1);
    endtask

    task automatic wait_complete(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!memComplete && cyc < 100);
        check_value({tag, "_complete"}, 64'(memComplete), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_memRead"}, 64'(memRead), 64'd0);
        check_value({tag, "_memAddress"}, 64'(memAddress), 64'(RST_PC));
        check_value({tag, "_instrValid"}, 64'(instrValid), 64'd0);
        check_value({tag, "_instrData"}, 64'(instrData), 64'd0);
        check_value({tag, "_instrPc"}, 64'(instrPc), 64'd0);
        check_value({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset = 1'b0; enable = 1'b0; redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // PC wrap from RESET_PC near the top of the address space
        #1; reset = 1'b1; enable = 1'b1; instrReady = 1'b1;
        base = got_pc.size();
        wait_got(base + 3, "wrap");
        check_got(base + 0, 32'hFFFF_FFFD, "wrap0");
        check_got(base + 1, 32'h0000_0002, "wrap1");
        check_got(base + 2, 32'h0000_0007, "wrap2");
        #1; enable = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while ((busy || instrValid) && cyc < 100);
        check_value("drain_idle", 64'(busy), 64'd0);

        // Restart at 0 with decode stalled: FIFO fills, fetch stalls, then resumes
        base = got_pc.size();
        #1; redirect = 1'b1; redirectPc = '0; enable = 1'b1; instrReady = 1'b0;
        @(negedge clk); #1; redirect = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(busy && !memRead && instrValid) && cyc < 100);
        check_value("stall_memRead", 64'(memRead), 64'd0);
        check_value("stall_head_pc", 64'(instrPc), 64'h0);
        check_value("stall_head_data", 64'(instrData), 64'(instr_at(32'h0)));
        repeat (10) @(negedge clk);
        check_value("stall_hold_memRead", 64'(memRead), 64'd0);
        check_value("stall_hold_busy", 64'(busy), 64'd1);
        check_value("stall_no_pop", 64'(got_pc.size()), 64'(base));
        #1; instrReady = 1'b1;
        wait_got(base + 4, "seq");
        check_got(base + 0, 32'd0, "seq0");
        check_got(base + 1, 32'd5, "seq1");
        check_got(base + 2, 32'd10, "seq2");
        check_got(base + 3, 32'd15, "seq3");

        // Redirect with a read in flight and one entry queued
        wait_complete("t3");
        #1; instrReady = 1'b0;
        @(negedge clk); @(negedge clk);
        check_value("t3_inflight_memRead", 64'(memRead), 64'd1);
        check_value("t3_inflight_noComplete", 64'(memComplete), 64'd0);
        check_value("t3_prefill_valid", 64'(instrValid), 64'd1);
        base = got_pc.size();
        #1; redirect = 1'b1; redirectPc = 32'h100;
        @(negedge clk);
        check_value("t3_flush_valid", 64'(instrValid), 64'd0);
        check_value("t3_discard_memRead", 64'(memRead), 64'd0);
        check_value("t3_discard_busy", 64'(busy), 64'd1);
        #1; redirect = 1'b0; instrReady = 1'b1;
        wait_got(base + 2, "t3");
        check_got(base + 0, 32'h100, "t3_first");
        check_got(base + 1, 32'h105, "t3_second");

        // Redirect coinciding with completion and a ready head
        wait_complete("t4a");
        #1; instrReady = 1'b0;
        wait_complete("t4b");
        check_value("t4_pre_valid", 64'(instrValid), 64'd1);
        base = got_pc.size();
        #1; redirect = 1'b1; redirectPc = 32'h200; instrReady = 1'b1;
        @(negedge clk);
        check_value("t4_flush_valid", 64'(instrValid), 64'd0);
        check_value("t4_memRead", 64'(memRead), 64'd1);
        check_value("t4_memAddress", 64'(memAddress), 64'h200);
        #1; redirect = 1'b0;
        wait_got(base + 1, "t4");
        check_got(base + 0, 32'h200, "t4_first");

        // Reset in the middle of a fetch; the late completion must be ignored
        wait_complete("t6");
        @(negedge clk); @(negedge clk);
        check_value("t6_inflight_memRead", 64'(memRead), 64'd1);
        #1; reset = 1'b0; enable = 1'b0; instrReady = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        #1; reset = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (model_busy && cyc < 50);
        repeat (3) @(negedge clk);
        check_value("t6_late_busy", 64'(busy), 64'd0);
        check_value("t6_late_valid", 64'(instrValid), 64'd0);
        check_value("t6_late_memRead", 64'(memRead), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
